addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_pkg.sv | 8 +
 rtl/addsub_arbiter_rr.sv | 22 ++
 rtl/addsub_arbiter.sv | 64 ++++++
 tb/tb_addsub_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/addsub_arbiter_pkg.sv
// addsub_arbiter_pkg: shared word size, op encodings and default sizing
package addsub_arbiter_pkg;
  localparam int WORD = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF = 7;
endpackage

// File: rtl/addsub_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o
);
  logic [IDW-1:0] j;
  // scan from the far end back toward ptr so the nearest request wins
  always_comb begin
    id_o = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr_i) + k) % NREQ);
      if (req_i[j]) id_o = j;
    end
    gnt_o = |req_i ? NREQ'(1) << id_o : '0;
  end
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one pipelined fpadd among NREQ requesters,
// tagging each grant so its result returns to the owner LAT+2 cycles later.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WORD-1:0] req_a,
  input  logic [NREQ*WORD-1:0] req_b,
  input  logic [NREQ-1:0]      req_op,
  output logic [WORD-1:0]      fu_a,
  output logic [WORD-1:0]      fu_b,
  output logic                 fu_op,
  output logic                 fu_ce,
  input  logic [WORD-1:0]      fu_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [WORD-1:0]      rsp_result
);
  localparam int IDW = $clog2(NREQ);
  logic [IDW-1:0] ptr_q, ptr_d, win_id;
  logic [NREQ-1:0] gnt;
  logic granted;
  logic [LAT:0] tv_q;
  logic [IDW-1:0] tid_q [LAT+1];
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .id_o(win_id)
  );
  assign req_ready = rst ? '0 : gnt;
  assign granted = |req_ready;
  assign fu_ce = ~rst;
  assign ptr_d = granted ? (win_id == IDW'(NREQ - 1) ? '0 : win_id + 1'b1) : ptr_q;
  // tags mirror the fpadd pipe; reset drops them so stale results never surface
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      tv_q <= '0;
      fu_a <= '0;
      fu_b <= '0;
      fu_op <= OP_ADD;
      rsp_valid <= '0;
      rsp_result <= '0;
    end else begin
      ptr_q <= ptr_d;
      tv_q <= {tv_q[LAT-1:0], granted};
      tid_q[0] <= win_id;
      for (int s = 1; s <= LAT; s++) tid_q[s] <= tid_q[s-1];
      if (granted) begin
        fu_a <= req_a[WORD*win_id +: WORD];
        fu_b <= req_b[WORD*win_id +: WORD];
        fu_op <= req_op[win_id];
      end
      rsp_valid <= tv_q[LAT] ? NREQ'(1) << tid_q[LAT] : '0;
      if (tv_q[LAT]) rsp_result <= fu_result;
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed steps with a round-robin reference and a
// result scoreboard fed by a behavioural fpadd pipe.
module tb_addsub_arbiter;
  localparam int NREQ = 4;
  localparam int LAT = 7;
  typedef struct {int id; logic [31:0] res; int due;} ent_t;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req_valid = '0, req_ready, req_op = '0, rsp_valid;
  logic [NREQ*32-1:0] req_a = '0, req_b = '0;
  logic [31:0] fu_a, fu_b, fu_result, rsp_result;
  logic fu_op, fu_ce;
  logic [31:0] pipe [LAT];
  logic [31:0] a_v [NREQ], b_v [NREQ];
  logic op_v [NREQ];
  ent_t q[$];
  ent_t e;
  int total = 0, bad = 0, cyc = 0, mptr = 0, rsp_cnt = 0, c0, saved;
  logic due;
  logic [NREQ-1:0] ev;

  addsub_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .fu_a(fu_a), .fu_b(fu_b),
    .fu_op(fu_op), .fu_ce(fu_ce), .fu_result(fu_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] s2d(logic [31:0] s);
    logic [10:0] ex;
    ex = {3'b000, s[30:23]} + 11'd896;
    return (s[30:0] == 0) ? {s[31], 63'b0} : {s[31], ex, s[22:0], 29'b0};
  endfunction

  function automatic logic [31:0] d2s(logic [63:0] d);
    logic [10:0] ex;
    ex = d[62:52] - 11'd896;
    return (d[62:0] == 0) ? {d[63], 31'b0} : {d[63], ex[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpadd(logic [31:0] a, logic [31:0] b, logic op);
    real ra, rb;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    return d2s($realtobits(op ? ra - rb : ra + rb));
  endfunction

  always @(posedge clk)
    if (fu_ce) begin
      pipe[0] <= fpadd(fu_a, fu_b, fu_op);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign fu_result = pipe[LAT-1];

  always @(negedge clk) begin
    due = q.size() > 0 && q[0].due == cyc;
    ev = due ? NREQ'(1) << q[0].id : '0;
    if (due || rsp_valid !== '0) begin
      total++;
      assert (rsp_valid === ev && (!due || rsp_result === q[0].res)) else begin
        bad++;
        $error("FAIL rsp cyc=%0d got v=%b r=%h want v=%b r=%h", cyc, rsp_valid,
               rsp_result, ev, due ? q[0].res : 32'h0);
      end
      if (due) e = q.pop_front();
      if (rsp_valid !== '0) rsp_cnt++;
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    a_v[i] = a;
    b_v[i] = b;
    op_v[i] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[i] = op;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v);
    int g;
    logic [NREQ-1:0] expg;
    req_valid = v;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && v[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
    expg = (g >= 0) ? NREQ'(1) << g : '0;
    check("grant", 32'(req_ready), 32'(expg));
    if (g >= 0) begin
      q.push_back('{g, fpadd(a_v[g], b_v[g], op_v[g]), cyc + LAT + 2});
      mptr = (g + 1) % NREQ;
    end
    @(posedge clk) #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    req_valid = '1;
    q.delete();
    mptr = 0;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_ce", 32'(fu_ce), 32'h0);
    repeat (n) @(posedge clk);
    #2;
    check("rst_fu_a", fu_a, 32'h0);
    check("rst_fu_b", fu_b, 32'h0);
    check("rst_fu_op", 32'(fu_op), 32'h0);
    check("rst_rsp_v", 32'(rsp_valid), 32'h0);
    check("rst_rsp_r", rsp_result, 32'h0);
    rst = 0;
    req_valid = '0;
    #1;
    check("ce_run", 32'(fu_ce), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h3F800000 + (i << 22), 32'h40000000, 1'b0);
    @(posedge clk) #2;
    do_reset(2);
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
    while (cyc < 5) step('0);
    c0 = cyc;
    step(4'b0001);
    check("fu_a", fu_a, 32'h3F800000);
    check("fu_b", fu_b, 32'h40000000);
    while (cyc < c0 + LAT + 2) step('0);
    #1;
    check("add_v", 32'(rsp_valid), 32'h1);
    check("add_r", rsp_result, 32'h40400000);
    set_op(2, 32'h40400000, 32'h3F800000, 1'b1);
    c0 = cyc;
    step(4'b0100);
    check("fu_op", 32'(fu_op), 32'h1);
    while (cyc < c0 + LAT + 2) step('0);
    #1;
    check("sub_v", 32'(rsp_valid), 32'h4);
    check("sub_r", rsp_result, 32'h40000000);
    step(4'b1001);
    step(4'b1001);
    step(4'b0100);
    step(4'b0011);
    step(4'b0000);
    repeat (LAT + 4) step('0);
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h40800000 + (i << 21), 32'h3F800000, i[0]);
    repeat (2 * NREQ) step('1);
    repeat (LAT + 4) step('0);
    repeat (3) step('1);
    repeat (2) step('0);
    saved = rsp_cnt;
    do_reset(1);
    repeat (LAT + 6) step('0);
    check("rst_pulses", 32'(rsp_cnt), 32'(saved));
    step('1);
    repeat (LAT + 4) step('0);
    check("drain", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
